sc_regshifter_flags: RTL

//  Shift register and status-flag unit at the datapath end of the uDATAPATH control interface.
//  - Consumes the state machine's regSHIFTER clear, load and shift-selection controls.
//  - Captures the ALU result and its overflow/carry.
//  - Returns registered, active-low overflow/carry/negative/zero flags to the state machine's flag inputs.

---
 rtl/sc_regshifter_flags_pkg.sv | 39 +++
 rtl/sc_regshifter_flags_encoder.sv | 30 +++
 rtl/sc_regshifter_flags.sv | 134 +++++++++++++
 3 files changed

// File: rtl/sc_regshifter_flags_pkg.sv
// -----------------------------------------------------------------------------
// sc_regshifter_flags_pkg
// Shared uDATAPATH definitions used by the shift register / flag unit and by
// the ALU status path.
//  - Shift-selection codes driven by the state machine.
//  - Packed active-low flag vector type {OV, C, N, Z} and its reset value.
//  - Helper that turns active-high flags into the active-low vector.
// -----------------------------------------------------------------------------
package sc_regshifter_flags_pkg;

  // Shift-selection codes; both NOP codes mean hold.
  localparam logic [1:0] SHIFT_NOP0  = 2'b00;
  localparam logic [1:0] SHIFT_LEFT  = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT = 2'b10;
  localparam logic [1:0] SHIFT_NOP1  = 2'b11;

  // Active-low status flags as seen by the state machine's *_InLow inputs.
  typedef struct packed {
    logic ov_n;
    logic c_n;
    logic n_n;
    logic z_n;
  } flags_n_t;

  // Cleared register: no overflow, no carry, not negative, zero.
  localparam flags_n_t FLAGS_N_RESET = 4'b1110;

  // Pack active-high flags into the active-low vector.
  function automatic flags_n_t encode_flags_n(input logic ov, input logic c,
                                              input logic n, input logic z);
    flags_n_t f;
    f.ov_n = ~ov;
    f.c_n  = ~c;
    f.n_n  = ~n;
    f.z_n  = ~z;
    return f;
  endfunction

endpackage

// File: rtl/sc_regshifter_flags_encoder.sv
// -----------------------------------------------------------------------------
// sc_flag_encoder
// Combinational flag encoder: derives N and Z from a data word and packs them
// with the supplied OV and C into the active-low {OV, C, N, Z} vector.
// Shared with the ALU status path; the caller decides whether to register it.
// Ports:
//   data    in  W  data word the N/Z flags describe
//   ov      in  1  overflow (active-high)
//   c       in  1  carry (active-high)
//   flags_n out 4  active-low {OV, C, N, Z}
// -----------------------------------------------------------------------------
module sc_flag_encoder
  import sc_regshifter_flags_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] data,
  input  logic         ov,
  input  logic         c,
  output flags_n_t     flags_n
);

  logic neg_s;
  logic zero_s;

  assign neg_s   = data[W-1];
  assign zero_s  = (data == {W{1'b0}});
  assign flags_n = encode_flags_n(ov, c, neg_s, zero_s);

endmodule

// File: rtl/sc_regshifter_flags.sv
// -----------------------------------------------------------------------------
// sc_regshifter_flags
// Shift register and status-flag unit at the datapath end of the uDATAPATH
// control interface. Captures the ALU result with its overflow/carry, shifts
// it on request and returns registered active-low OV/C/N/Z flags.
// One action per clock edge, priority reset > clear > load > shift > hold.
// All outputs come straight from flops.
// Configuration macro: SC_REGSHIFTER_ROTATE_EN -- when defined, shifts rotate
// (left fill = D[W-1], right fill = D[0]); otherwise logical zero-fill shifts.
// Ports:
//   SC_REGSHIFTER_CLOCK_50             in   1  clock, rising edge
//   SC_REGSHIFTER_RESET_InLow          in   1  synchronous reset, active-low
//   SC_REGSHIFTER_clear_InLow          in   1  0 = clear register and flags
//   SC_REGSHIFTER_load_InLow           in   1  0 = load data and ALU flags
//   SC_REGSHIFTER_shiftselection_InBUS in   S  01 left, 10 right, else hold
//   SC_REGSHIFTER_data_InBUS           in   W  ALU result
//   SC_REGSHIFTER_aluoverflow_InHigh   in   1  ALU overflow
//   SC_REGSHIFTER_alucarry_InHigh      in   1  ALU carry
//   SC_REGSHIFTER_data_OutBUS          out  W  register contents
//   SC_REGSHIFTER_overflow_OutLow      out  1  0 = overflow
//   SC_REGSHIFTER_carry_OutLow         out  1  0 = carry / shifted-out 1
//   SC_REGSHIFTER_negative_OutLow      out  1  0 = data MSB set
//   SC_REGSHIFTER_zero_OutLow          out  1  0 = data is zero
// -----------------------------------------------------------------------------
module sc_regshifter_flags
  import sc_regshifter_flags_pkg::*;
#(
  parameter int DATAWIDTH_BUS                  = 8,
  parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2
) (
  input  logic                                      SC_REGSHIFTER_CLOCK_50,
  input  logic                                      SC_REGSHIFTER_RESET_InLow,
  input  logic                                      SC_REGSHIFTER_clear_InLow,
  input  logic                                      SC_REGSHIFTER_load_InLow,
  input  logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_REGSHIFTER_shiftselection_InBUS,
  input  logic [DATAWIDTH_BUS-1:0]                  SC_REGSHIFTER_data_InBUS,
  input  logic                                      SC_REGSHIFTER_aluoverflow_InHigh,
  input  logic                                      SC_REGSHIFTER_alucarry_InHigh,
  output logic [DATAWIDTH_BUS-1:0]                  SC_REGSHIFTER_data_OutBUS,
  output logic                                      SC_REGSHIFTER_overflow_OutLow,
  output logic                                      SC_REGSHIFTER_carry_OutLow,
  output logic                                      SC_REGSHIFTER_negative_OutLow,
  output logic                                      SC_REGSHIFTER_zero_OutLow
);

  localparam int W = DATAWIDTH_BUS;

  logic [W-1:0] data_r;
  flags_n_t     flags_r;

  logic [W-1:0] next_data_s;
  logic         next_ov_s;
  logic         next_c_s;
  logic         update_s;
  logic         fill_left_s;
  logic         fill_right_s;
  flags_n_t     enc_flags_s;

  // Bit shifted into the vacated position: wrapped-around bit when rotating.
`ifdef SC_REGSHIFTER_ROTATE_EN
  assign fill_left_s  = data_r[W-1];
  assign fill_right_s = data_r[0];
`else
  assign fill_left_s  = 1'b0;
  assign fill_right_s = 1'b0;
`endif

  // Next data/OV/C selection by priority clear > load > shift > hold.
  always_comb begin
    next_data_s = data_r;
    next_ov_s   = 1'b0;
    next_c_s    = 1'b0;
    update_s    = 1'b0;
    if (!SC_REGSHIFTER_clear_InLow) begin
      // Zero data with OV=C=0 encodes to the reset flag vector.
      update_s    = 1'b1;
      next_data_s = {W{1'b0}};
    end else if (!SC_REGSHIFTER_load_InLow) begin
      update_s    = 1'b1;
      next_data_s = SC_REGSHIFTER_data_InBUS;
      next_ov_s   = SC_REGSHIFTER_aluoverflow_InHigh;
      next_c_s    = SC_REGSHIFTER_alucarry_InHigh;
    end else begin
      case (SC_REGSHIFTER_shiftselection_InBUS)
        SHIFT_LEFT: begin
          update_s    = 1'b1;
          next_data_s = {data_r[W-2:0], fill_left_s};
          next_c_s    = data_r[W-1];
          // Sign change: new MSB is old D[W-2].
          next_ov_s   = data_r[W-1] ^ data_r[W-2];
        end
        SHIFT_RIGHT: begin
          update_s    = 1'b1;
          next_data_s = {fill_right_s, data_r[W-1:1]};
          next_c_s    = data_r[0];
          next_ov_s   = 1'b0;
        end
        default: begin
          update_s    = 1'b0;
        end
      endcase
    end
  end

  sc_flag_encoder #(
    .W(W)
  ) u_flag_encoder (
    .data    (next_data_s),
    .ov      (next_ov_s),
    .c       (next_c_s),
    .flags_n (enc_flags_s)
  );

  // Register stage: synchronous reset, otherwise update on any action.
  always_ff @(posedge SC_REGSHIFTER_CLOCK_50) begin
    if (!SC_REGSHIFTER_RESET_InLow) begin
      data_r  <= {W{1'b0}};
      flags_r <= FLAGS_N_RESET;
    end else if (update_s) begin
      data_r  <= next_data_s;
      flags_r <= enc_flags_s;
    end else begin
      data_r  <= data_r;
      flags_r <= flags_r;
    end
  end

  assign SC_REGSHIFTER_data_OutBUS     = data_r;
  assign SC_REGSHIFTER_overflow_OutLow = flags_r.ov_n;
  assign SC_REGSHIFTER_carry_OutLow    = flags_r.c_n;
  assign SC_REGSHIFTER_negative_OutLow = flags_r.n_n;
  assign SC_REGSHIFTER_zero_OutLow     = flags_r.z_n;

endmodule
